// File: rtl/pu_issue.sv
// -----------------------------------------------------------------------------
// pu_issue
//
// Command issuer and result collector for the processing unit (pu).
// Operand-pair commands are buffered in a DEPTH-entry FIFO. A two-state issue
// FSM then drives them onto the pu entry interface: lane data, per-lane valid
// and row-0 op select. Each command stays on the interface until pu accepts it
// with pu_rdy. Buffered pu results are caught in a 2-entry skid buffer and
// returned downstream in order, with a 4-bit sequence tag.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   cmd_*            command stream in: valid/ready, pair, op, operands a/b
//   pu_data/pu_dv    pu lane data (8x32) and per-lane valid (8)
//   pu_op_r0         pu row-0 op select, one 4-bit op per lane pair
//   pu_rdy           pu entry ready
//   pu_res_*         pu buffered result: data, valid, and our ready back
//   res_*            result stream out: data, tag, valid/ready
//   outstanding      commands issued but not yet returned downstream
// -----------------------------------------------------------------------------
module pu_issue #(
    parameter int DEPTH   = 4,   // command FIFO depth, power of 2, >= 2
    parameter int MAX_OUT = 8    // in-flight command limit, 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_pair,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic [7:0][31:0] pu_data,
    output logic [7:0]       pu_dv,
    output logic [3:0][3:0]  pu_op_r0,
    input  logic             pu_rdy,
    input  logic [31:0]      pu_res_data,
    input  logic             pu_res_dv,
    output logic             pu_res_rdy,
    output logic [31:0]      res_data,
    output logic [3:0]       res_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       outstanding
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]  pair;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    cmd_t          cmd_mem [DEPTH];
    logic [AW-1:0] cmd_wr_ptr;
    logic [AW-1:0] cmd_rd_ptr;
    logic [AW:0]   cmd_count;
    logic          cmd_full;
    logic          cmd_empty;
    logic          cmd_push;
    logic          cmd_pop;
    cmd_t          cmd_head;

    assign cmd_full  = (cmd_count == (AW+1)'(DEPTH));
    assign cmd_empty = (cmd_count == '0);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem[cmd_rd_ptr];

    // NOTE: the storage array has no reset. Its contents are ignored until the
    // pointers and count (which are reset) mark an entry valid, so a reset here
    // would only add fan-out on rst.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= '{pair: cmd_pair, op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    // NOTE: every clocked block uses non-blocking assignments. All registers
    // then sample their inputs from the same pre-edge values, whatever order
    // the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + AW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + AW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + (AW+1)'(1);
                2'b01:   cmd_count <= cmd_count - (AW+1)'(1);
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------
    state_t state;
    state_t state_nxt;
    logic   credit_ok;
    logic   issue;
    logic   drop_dv;
    logic   res_pop;

    // Credit is judged on the registered count only. A result pop therefore
    // frees a slot for the following edge, not the same one.
    assign credit_ok = (outstanding < 4'(MAX_OUT));
    assign cmd_pop   = issue;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: each output of this block gets a default before the case, so every
    // path assigns every signal and no latch is inferred.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        drop_dv   = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && credit_ok) begin
                    issue     = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                // Hold the entry interface until pu takes it. Then either
                // chain the next command or drop valid.
                if (pu_rdy) begin
                    if (!cmd_empty && credit_ok) begin
                        issue = 1'b1;
                    end else begin
                        drop_dv   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry interface: only the loaded pair changes. Other lanes and ops keep
    // their previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pu_data  <= '0;
            pu_dv    <= '0;
            pu_op_r0 <= '0;
        end else if (issue) begin
            pu_data[{cmd_head.pair, 1'b0}] <= cmd_head.a;
            pu_data[{cmd_head.pair, 1'b1}] <= cmd_head.b;
            pu_op_r0[cmd_head.pair]        <= cmd_head.op;
            pu_dv                          <= 8'b0000_0011 << {cmd_head.pair, 1'b0};
        end else if (drop_dv) begin
            pu_dv <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Result skid buffer (2 entries)
    // -------------------------------------------------------------------------
    logic [31:0] skid_mem [2];
    logic        skid_wr_ptr;
    logic        skid_rd_ptr;
    logic [1:0]  skid_count;
    logic        skid_push;

    assign pu_res_rdy = (skid_count != 2'd2);
    assign res_valid  = (skid_count != 2'd0);
    assign res_data   = skid_mem[skid_rd_ptr];
    assign skid_push  = pu_res_dv && pu_res_rdy;
    assign res_pop    = res_valid && res_ready;

    // Unlike the command FIFO, these two words are cleared on reset. res_data
    // reads the head entry directly and must be zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
            skid_count  <= '0;
        end else begin
            if (skid_push) begin
                skid_mem[skid_wr_ptr] <= pu_res_data;
                skid_wr_ptr           <= ~skid_wr_ptr;
            end
            if (res_pop) skid_rd_ptr <= ~skid_rd_ptr;
            case ({skid_push, res_pop})
                2'b10:   skid_count <= skid_count + 2'd1;
                2'b01:   skid_count <= skid_count - 2'd1;
                default: skid_count <= skid_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequence tag and in-flight count
    // -------------------------------------------------------------------------
    // pu preserves order, so counting downstream pops reproduces the issue
    // index mod 16.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_tag     <= '0;
            outstanding <= '0;
        end else begin
            if (res_pop) res_tag <= res_tag + 4'd1;
            case ({issue, res_pop})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_pu_issue.sv
// -----------------------------------------------------------------------------
// tb_pu_issue
//
// Bench for pu_issue. It contains a small behavioural pu model: it accepts
// entries, computes lane 2p + lane 2p+1 + op, and returns results in order.
// It also keeps a scoreboard. Each accepted command pushes the expected entry,
// the expected result and the expected tag. These are popped and compared when
// the DUT issues to pu and when it hands a result downstream.
// -----------------------------------------------------------------------------
module tb_pu_issue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_pair;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [7:0][31:0] pu_data;
    logic [7:0]       pu_dv;
    logic [3:0][3:0]  pu_op_r0;
    logic             pu_rdy;
    logic [31:0]      pu_res_data;
    logic             pu_res_dv;
    logic             pu_res_rdy;
    logic [31:0]      res_data;
    logic [3:0]       res_tag;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       outstanding;

    pu_issue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_pair    (cmd_pair),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .pu_data     (pu_data),
        .pu_dv       (pu_dv),
        .pu_op_r0    (pu_op_r0),
        .pu_rdy      (pu_rdy),
        .pu_res_data (pu_res_data),
        .pu_res_dv   (pu_res_dv),
        .pu_res_rdy  (pu_res_rdy),
        .res_data    (res_data),
        .res_tag     (res_tag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pair;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t        iss_q[$];       // expected pu entries, in order
    logic [31:0] exp_data_q[$];  // expected downstream data
    logic [3:0]  exp_tag_q[$];   // expected downstream tags
    logic [31:0] pu_q[$];        // results held inside the pu model

    int         checks    = 0;
    int         errors    = 0;
    int         n_issued  = 0;
    int         n_results = 0;
    logic [3:0] tb_tag    = 4'd0;
    bit         rdy_rand  = 1'b0;
    bit         rr_rand   = 1'b0;
    bit         pres_rand = 1'b0;
    bit         accepted  = 1'b0;

    // One clock. Handshakes are observed at the falling edge, before the
    // rising edge that completes them. Random inputs and the pu model outputs
    // are then updated 1 time unit after the rising edge.
    task automatic tick();
        cmd_t e;
        int   mp;
        bit   res_hs;
        @(negedge clk);
        accepted = 1'b0;
        res_hs   = 1'b0;
        mp       = 0;
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                accepted = 1'b1;
                e.pair = cmd_pair; e.op = cmd_op; e.a = cmd_a; e.b = cmd_b;
                iss_q.push_back(e);
                exp_data_q.push_back(cmd_a + cmd_b + 32'(cmd_op));
                exp_tag_q.push_back(tb_tag);
                tb_tag = tb_tag + 4'd1;
            end
            if (pu_dv != 8'h00 && pu_rdy) begin
                checks++;
                if (iss_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_issue: pu_dv=%h, expected no issue", pu_dv);
                end else begin
                    e = iss_q.pop_front();
                    if (pu_dv !== (8'b11 << (2 * int'(e.pair))) ||
                        pu_data[2*int'(e.pair)] !== e.a ||
                        pu_data[2*int'(e.pair)+1] !== e.b ||
                        pu_op_r0[e.pair] !== e.op) begin
                        errors++;
                        $display("FAIL issue_entry: dv=%h a=%h b=%h op=%h, expected pair %0d a=%h b=%h op=%h",
                                 pu_dv, pu_data[2*int'(e.pair)], pu_data[2*int'(e.pair)+1],
                                 pu_op_r0[e.pair], e.pair, e.a, e.b, e.op);
                    end
                end
                for (int i = 0; i < 4; i++) if (pu_dv[2*i]) mp = i;
                pu_q.push_back(pu_data[2*mp] + pu_data[2*mp+1] + 32'(pu_op_r0[mp]));
                n_issued++;
            end
            if (pu_res_dv && pu_res_rdy) begin
                res_hs = 1'b1;
                void'(pu_q.pop_front());
            end
            if (res_valid && res_ready) begin
                checks++;
                n_results++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_result: data=%h tag=%0d, expected none", res_data, res_tag);
                end else begin
                    if (res_data !== exp_data_q[0] || res_tag !== exp_tag_q[0]) begin
                        errors++;
                        $display("FAIL result: data=%h tag=%0d, expected data=%h tag=%0d",
                                 res_data, res_tag, exp_data_q[0], exp_tag_q[0]);
                    end
                    void'(exp_data_q.pop_front());
                    void'(exp_tag_q.pop_front());
                end
            end
            checks++;
            if (outstanding > 4'(MAX_OUT)) begin
                errors++;
                $display("FAIL credit_bound: outstanding=%0d, expected <= %0d", outstanding, MAX_OUT);
            end
        end
        @(posedge clk);
        #1;
        if (rdy_rand) pu_rdy    = 1'($urandom_range(0, 1));
        if (rr_rand)  res_ready = 1'($urandom_range(0, 1));
        if (rst) begin
            pu_res_dv = 1'b0;
        end else if (pu_res_dv && !res_hs) begin
            pu_res_dv = 1'b1;  // pu holds an unaccepted result
        end else if (pu_q.size() > 0 && (!pres_rand || $urandom_range(0, 2) != 0)) begin
            pu_res_dv   = 1'b1;
            pu_res_data = pu_q[0];
        end else begin
            pu_res_dv = 1'b0;
        end
    endtask

    // Presents a command and waits (bounded) until it is accepted. cmd_valid
    // is left high so the caller can chain the next command.
    task automatic push_cmd(input logic [1:0] p, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        cmd_pair = p; cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL push_timeout: pair=%0d not accepted, expected acceptance within 200 cycles", p);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((iss_q.size() != 0 || exp_data_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (iss_q.size() != 0 || exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries and %0d results pending, expected 0 and 0",
                     name, iss_q.size(), exp_data_q.size());
        end
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL %s_outstanding: got %0d, expected 0", name, outstanding);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_pair = '0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        pu_rdy = 1'b0; pu_res_dv = 1'b0; pu_res_data = '0; res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || pu_res_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b pu_res_rdy=%b, expected 1 1", cmd_ready, pu_res_rdy);
        end
        checks++;
        if (pu_data !== '0 || pu_dv !== 8'h00 || pu_op_r0 !== '0) begin
            errors++;
            $display("FAIL reset_pu: dv=%h op=%h data_nonzero=%b, expected all 0",
                     pu_dv, pu_op_r0, |pu_data);
        end
        checks++;
        if (res_data !== 32'h0 || res_tag !== 4'd0 || res_valid !== 1'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL reset_res: data=%h tag=%0d valid=%b outstanding=%0d, expected 0 0 0 0",
                     res_data, res_tag, res_valid, outstanding);
        end
    endtask

    task automatic test_single_issue();
        pu_rdy = 1'b0; res_ready = 1'b0;
        push_cmd(2'd0, 4'd0, 32'd345, 32'd15);  // push edge N
        cmd_valid = 1'b0;
        checks++;
        if (pu_dv !== 8'h00) begin
            errors++;
            $display("FAIL single_no_bypass: pu_dv=%h after push edge, expected 00", pu_dv);
        end
        tick();                                 // edge N+1
        checks++;
        if (pu_dv !== 8'h03 || pu_data[0] !== 32'd345 || pu_data[1] !== 32'd15) begin
            errors++;
            $display("FAIL single_drive: dv=%h d0=%0d d1=%0d, expected 03 345 15",
                     pu_dv, pu_data[0], pu_data[1]);
        end
        checks++;
        if (outstanding !== 4'd1) begin
            errors++;
            $display("FAIL single_count: outstanding=%0d, expected 1", outstanding);
        end
        repeat (3) tick();
        checks++;
        if (pu_dv !== 8'h03 || pu_data[0] !== 32'd345 || pu_data[1] !== 32'd15) begin
            errors++;
            $display("FAIL single_hold: dv=%h d0=%0d d1=%0d, expected 03 345 15",
                     pu_dv, pu_data[0], pu_data[1]);
        end
        pu_rdy = 1'b1;
        tick();
        pu_rdy = 1'b0;
        checks++;
        if (pu_dv !== 8'h00 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL single_accept: dv=%h outstanding=%0d, expected 00 1", pu_dv, outstanding);
        end
        res_ready = 1'b1;
        drain("single", 50);
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_issued;
        rdy_rand = 1'b1; rr_rand = 1'b1; pres_rand = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(2'(i), 4'(i), $urandom, $urandom);
        cmd_valid = 1'b0;
        drain("b2b", 400);
        rdy_rand = 1'b0; rr_rand = 1'b0; pres_rand = 1'b0;
        pu_rdy = 1'b0; res_ready = 1'b0;
        checks++;
        if (pu_op_r0 !== {4'd3, 4'd2, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL b2b_ops: pu_op_r0=%h, expected 3210", pu_op_r0);
        end
        checks++;
        if (n_issued - base != 4) begin
            errors++;
            $display("FAIL b2b_count: issued %0d, expected 4", n_issued - base);
        end
    endtask

    task automatic test_credit_limit();
        int base;
        base = n_issued;
        pu_rdy = 1'b1; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(2'(i), 4'(i + 4), $urandom, $urandom);
        cmd_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_issued - base != 2 || outstanding !== 4'd2 || pu_dv !== 8'h00) begin
            errors++;
            $display("FAIL credit_stall: issued=%0d outstanding=%0d dv=%h, expected 2 2 00",
                     n_issued - base, outstanding, pu_dv);
        end
        checks++;
        if (cmd_ready !== 1'b1 || pu_res_rdy !== 1'b0) begin
            errors++;
            $display("FAIL credit_buffers: cmd_ready=%b pu_res_rdy=%b, expected 1 0", cmd_ready, pu_res_rdy);
        end
        push_cmd(2'd0, 4'd8, $urandom, $urandom);
        push_cmd(2'd1, 4'd9, $urandom, $urandom);
        cmd_pair = 2'd2; cmd_op = 4'hF; cmd_a = 32'hDEAD_BEEF; cmd_b = 32'hDEAD_BEEF;
        repeat (3) tick();                      // refused while full
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: cmd_ready=%b, expected 0", cmd_ready);
        end
        res_ready = 1'b1;
        tick();                                 // downstream pop at edge M
        res_ready = 1'b0;
        checks++;
        if (pu_dv !== 8'h00 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL credit_edge_m: dv=%h outstanding=%0d, expected 00 1", pu_dv, outstanding);
        end
        tick();                                 // issue at edge M+1
        checks++;
        if (pu_dv !== 8'h30) begin
            errors++;
            $display("FAIL credit_release: dv=%h, expected 30", pu_dv);
        end
        res_ready = 1'b1;
        drain("credit", 300);
        res_ready = 1'b0; pu_rdy = 1'b0;
        checks++;
        if (n_issued - base != 6) begin
            errors++;
            $display("FAIL credit_count: issued %0d, expected 6", n_issued - base);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        pu_rdy = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(2'(i), 4'(i), $urandom, $urandom);
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (pu_dv !== 8'h03) begin
            errors++;
            $display("FAIL midrst_drive: dv=%h, expected 03", pu_dv);
        end
        // pu is reset together with the DUT, so the model and scoreboard are cleared.
        iss_q.delete(); exp_data_q.delete(); exp_tag_q.delete(); pu_q.delete();
        tb_tag = 4'd0;
        rst = 1'b1;
        tick();
        checks++;
        if (pu_dv !== 8'h00 || pu_data !== '0 || pu_op_r0 !== '0 || cmd_ready !== 1'b1 ||
            pu_res_rdy !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0 ||
            res_tag !== 4'd0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL midrst_values: dv=%h cmd_ready=%b valid=%b tag=%0d outstanding=%0d, expected reset values",
                     pu_dv, cmd_ready, res_valid, res_tag, outstanding);
        end
        rst = 1'b0;
        base = n_issued;
        pu_rdy = 1'b1;
        repeat (10) tick();
        pu_rdy = 1'b0;
        checks++;
        if (n_issued != base || pu_dv !== 8'h00 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL midrst_dropped: issued=%0d dv=%h outstanding=%0d, expected 0 00 0",
                     n_issued - base, pu_dv, outstanding);
        end
    endtask

    task automatic test_result_path();
        int base;
        base = n_results;
        rdy_rand = 1'b1; rr_rand = 1'b1; pres_rand = 1'b1;
        for (int i = 0; i < 20; i++)
            push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom, $urandom);
        cmd_valid = 1'b0;
        drain("result", 2000);
        rdy_rand = 1'b0; rr_rand = 1'b0; pres_rand = 1'b0;
        checks++;
        if (n_results - base != 20 || res_tag !== 4'd4) begin
            errors++;
            $display("FAIL result_count: results=%0d tag=%0d, expected 20 4", n_results - base, res_tag);
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_credit_limit();
        test_mid_reset();
        test_result_path();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_issue.md
# pu_issue

Command issuer and result collector for the processing unit (`pu`). It accepts operand-pair commands on a valid/ready stream and drives the `pu` entry interface: lane data, per-lane valid, and row-0 op select. It honours the `pu` ready handshake, collects buffered row-2 results through a 2-entry skid buffer, and returns them downstream with an in-order sequence tag. It sits between the command fabric and `pu`, on the opposite side of every `pu` data port.

## Interface
- `DEPTH`, 4, command FIFO depth (power of 2, ≥2)
- `MAX_OUT`, 8, max commands issued but not yet returned downstream (1..15)
---
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `cmd_valid`  in  1  command valid
- `cmd_ready`  out  1  command FIFO not full
- `cmd_pair`  in  2  lane pair p; drives lanes 2p and 2p+1
- `cmd_op`  in  4  row-0 op for pair p
- `cmd_a`  in  32  operand to lane 2p
- `cmd_b`  in  32  operand to lane 2p+1
- `pu_data`  out  8x32  `pu` i_data
- `pu_dv`  out  8  `pu` i_dv
- `pu_op_r0`  out  4x4  `pu` op_r0
- `pu_rdy`  in  1  `pu` o_rdy
- `pu_res_data`  in  32  `pu` o_data_buff
- `pu_res_dv`  in  1  `pu` o_dv_buff
- `pu_res_rdy`  out  1  `pu` i_rdy_buff
- `res_data`  out  32  result
- `res_tag`  out  4  result sequence number, mod 16
- `res_valid`  out  1  result valid
- `res_ready`  in  1  downstream ready
- `outstanding`  out  4  in-flight command count

## Operation
- **Command FIFO**
  - DEPTH entries of {pair, op, a, b}.
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = !full` (registered state).
- **Issue FSM**, states IDLE and DRIVE.
  - **IDLE → DRIVE**
    - Condition: FIFO non-empty and `outstanding < MAX_OUT`.
    - Action: pop the head.
    - Load `pu_data[2p]=a`, `pu_data[2p+1]=b`, `pu_op_r0[p]=op`.
    - Set `pu_dv` bits 2p and 2p+1 only.
    - `outstanding` increments.
  - **DRIVE**
    - `pu_dv`, `pu_data` and `pu_op_r0` are held stable until an edge where `pu_rdy=1` (entry handshake).
    - On handshake, if the FIFO is non-empty and `outstanding < MAX_OUT`, pop the next command in the same edge and stay in DRIVE (back-to-back issue).
    - Otherwise clear `pu_dv` to 0 and go to IDLE.
- **Output hold rules**
  - `pu_data` lanes and `pu_op_r0` entries not being loaded keep their last values.
  - Only the active pair's `pu_dv` bits are ever 1.
- **Result skid buffer**
  - 2-entry FIFO.
  - Push on `pu_res_dv & pu_res_rdy`.
  - `pu_res_rdy = !full`.
  - `res_valid = !empty`; `res_data` is the head entry.
  - Pop on `res_valid & res_ready`.
- **Tags**
  - `res_tag` is a 4-bit counter that increments on each downstream pop.
  - `pu` preserves order, so the tag equals the issue index mod 16.
  - The issue index also increments on each pop from the command FIFO into DRIVE.
- **`outstanding` counter**
  - +1 on each issue pop, −1 on each downstream result pop.
  - Both in the same edge: unchanged.
  - Never exceeds `MAX_OUT`; underflow cannot occur.

## Timing
- **Reset values:** `cmd_ready=1`, `pu_data=0`, `pu_dv=0`, `pu_op_r0=0`, `pu_res_rdy=1`, `res_data=0`, `res_tag=0`, `res_valid=0`, `outstanding=0`. State is IDLE and both FIFOs are empty.
- **Reset mid-operation:** pending and in-flight commands are dropped and results discarded. `pu` must be reset in the same cycles.
- **Command latency:** a command pushed at edge N into an empty FIFO (IDLE, room available) is popped at edge N+1, so `pu_dv` is high after edge N+1. There is no combinational bypass.
- **Throughput:** one command per cycle while `pu_rdy=1` and credit is available.
- **Credit stall:** with `outstanding = MAX_OUT`, no pop occurs. A downstream result pop at edge M makes issue possible at edge M+1.
- **FIFO full:** `cmd_ready=0` with `cmd_valid=1` causes no push and no data change.
- **Simultaneous push and pop when full:** not allowed (`cmd_ready` reflects the full state only).
- **Skid buffer full:** `pu_res_rdy=0`. `pu` must hold its result.
- **Simultaneous skid push and pop:** permitted at any fill level.
- **Tag wrap-around:** `res_tag` wraps 15 → 0.

## Test plan
- **Reset:** after reset release, all outputs are at the reset values listed above, and `cmd_ready=1`, `pu_res_rdy=1`.
- **Single issue:** pair=0, op=0, a=345, b=15 pushed at edge N → `pu_dv=8'b00000011`, `pu_data[0]=345`, `pu_data[1]=15` after edge N+1. Held until `pu_rdy` is seen, then `pu_dv=0` and `outstanding=1`.
- **Back-to-back with stalls:** pairs 0,1,2,3 with ops 0,1,2,3 and `pu_rdy` random → `pu_dv` goes 0x03, 0x0C, 0x30, 0xC0 in order. `pu_op_r0` ends at {3,2,1,0}. No command is lost or duplicated.
- **Credit limit:** `MAX_OUT=2`, `res_ready=0`, 4 commands → exactly 2 issue pops, `outstanding=2`, and `pu_dv` stays 0. Asserting `res_ready` releases the rest.
- **Result path:** 20 results from the `pu` model, with `pu_res_dv` and `res_ready` random → `res_data` sequence matches input, `res_tag` counts 0..15,0..3, and no result is dropped when the skid buffer is full.
- **Mid-operation reset:** reset in DRIVE with 3 queued commands → outputs take reset values in the next cycle, and no queued command is issued after release.
